// File: rtl/nic_link_allocator.sv
// nic_link_allocator: round-robin grant of the NIC->NoC link among fifo_out_buffers,
// optionally holding the link for a whole packet until its tail flit is granted.
module nic_link_allocator #(
  parameter int N_FIFO_OUT_BUFFER      = 6,
  parameter int N_BITS_FIFO_OUT_BUFFER = 3,
  parameter bit LOCK_PACKET            = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_FIFO_OUT_BUFFER-1:0]      r_la_i,
  input  logic [N_FIFO_OUT_BUFFER-1:0]      tail_i,
  input  logic                              link_ready_i,
  output logic                              g_la_o,
  output logic [N_BITS_FIFO_OUT_BUFFER-1:0] g_la_fifo_out_buffer_id_o,
  output logic [N_FIFO_OUT_BUFFER-1:0]      g_la_onehot_o,
  output logic                              locked_o,
  output logic [N_BITS_FIFO_OUT_BUFFER-1:0] lock_owner_o
);
  localparam int N = N_FIFO_OUT_BUFFER;
  localparam int W = N_BITS_FIFO_OUT_BUFFER;
  typedef enum logic {FREE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [W-1:0] prio_ptr, prio_nxt, owner, owner_nxt, pick, sel;
  logic [W:0] idx;
  logic grant, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      prio_ptr <= '0;
      owner    <= '0;
    end else begin
      state    <= state_nxt;
      prio_ptr <= prio_nxt;
      owner    <= owner_nxt;
    end
  end
  // Scan from the farthest offset down so the requester nearest prio_ptr wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx  = {1'b0, prio_ptr} + (W+1)'(i);
      idx  = idx >= (W+1)'(N) ? idx - (W+1)'(N) : idx;
      pick = r_la_i[idx[W-1:0]] ? idx[W-1:0] : pick;
    end
  end
  always_comb begin
    sel       = state == LOCKED ? owner : pick;
    grant     = !rst && link_ready_i && r_la_i[sel];
    last      = tail_i[sel] || !LOCK_PACKET;
    state_nxt = grant ? (last ? FREE : LOCKED) : state;
    prio_nxt  = grant && last ? (sel == W'(N - 1) ? '0 : sel + W'(1)) : prio_ptr;
    owner_nxt = grant && !last ? sel : owner;
  end
  always_comb begin
    g_la_o                    = grant;
    g_la_fifo_out_buffer_id_o = grant ? sel : '0;
    g_la_onehot_o             = grant ? N'(1) << sel : '0;
    locked_o                  = state == LOCKED;
    lock_owner_o              = state == LOCKED ? owner : '0;
  end
endmodule

// File: tb/tb_nic_link_allocator.sv
// tb_nic_link_allocator: directed and random stimulus checked against a per-cycle
// reference model of round-robin allocation with packet locking.
module tb_nic_link_allocator;
  localparam int N = 6;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] r_la, tail, onehot;
  logic link_ready, g_la, locked;
  logic [W-1:0] id, owner;
  int n_chk = 0;
  int n_fail = 0;
  bit m_locked = 1'b0;
  int m_ptr = 0;
  int m_owner = 0;

  nic_link_allocator #(.N_FIFO_OUT_BUFFER(N), .N_BITS_FIFO_OUT_BUFFER(W), .LOCK_PACKET(1'b1)) dut (
    .clk(clk), .rst(rst), .r_la_i(r_la), .tail_i(tail), .link_ready_i(link_ready),
    .g_la_o(g_la), .g_la_fifo_out_buffer_id_o(id), .g_la_onehot_o(onehot),
    .locked_o(locked), .lock_owner_o(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rs, input logic [N-1:0] r, input logic [N-1:0] t, input logic lr);
    int k;
    bit eg;
    bit found;
    rst = rs;
    r_la = r;
    tail = t;
    link_ready = lr;
    #1;
    k = 0;
    eg = 1'b0;
    found = 1'b0;
    if (!rs) begin
      if (m_locked) begin
        k = m_owner;
        eg = lr && r[k];
      end else begin
        for (int i = 0; i < N; i++)
          if (!found && r[(m_ptr + i) % N]) begin
            found = 1'b1;
            k = (m_ptr + i) % N;
          end
        eg = lr && found;
      end
    end
    chk("g_la", 32'(g_la), 32'(eg));
    chk("grant_id", 32'(id), eg ? k : 0);
    chk("onehot", 32'(onehot), eg ? (1 << k) : 0);
    if (!rs) begin
      chk("locked", 32'(locked), 32'(m_locked));
      chk("lock_owner", 32'(owner), m_locked ? m_owner : 0);
    end
    @(posedge clk);
    if (rs) begin
      m_locked = 1'b0;
      m_ptr = 0;
      m_owner = 0;
    end else if (eg) begin
      if (t[k]) begin
        m_locked = 1'b0;
        m_ptr = (k + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner = k;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    step(1'b1, 6'b000000, 6'b000000, 1'b1);
    step(1'b1, 6'b000000, 6'b000000, 1'b1);
    // Basic round robin: 0 then 2
    step(1'b0, 6'b000101, 6'b111111, 1'b1);
    step(1'b0, 6'b000101, 6'b111111, 1'b1);
    // Move pointer to 5, then wrap 5 -> 0
    step(1'b0, 6'b010000, 6'b111111, 1'b1);
    step(1'b0, 6'b100001, 6'b111111, 1'b1);
    step(1'b0, 6'b100001, 6'b111111, 1'b1);
    // Four-flit packet from 1 while 2 keeps requesting
    step(1'b0, 6'b000110, 6'b000000, 1'b1);
    step(1'b0, 6'b000110, 6'b000000, 1'b1);
    step(1'b0, 6'b000110, 6'b000000, 1'b1);
    chk("tp3_locked", 32'(locked), 1);
    step(1'b0, 6'b000110, 6'b000010, 1'b1);
    step(1'b0, 6'b000100, 6'b111111, 1'b1);
    // Owner 3 bubbles for two cycles while 0 requests
    step(1'b0, 6'b001001, 6'b000000, 1'b1);
    step(1'b0, 6'b000001, 6'b111111, 1'b1);
    step(1'b0, 6'b000001, 6'b111111, 1'b1);
    step(1'b0, 6'b001001, 6'b001000, 1'b1);
    step(1'b0, 6'b000001, 6'b111111, 1'b1);
    // Link stall holds everything
    step(1'b0, 6'b111111, 6'b111111, 1'b0);
    step(1'b0, 6'b111111, 6'b111111, 1'b0);
    step(1'b0, 6'b111111, 6'b111111, 1'b0);
    step(1'b0, 6'b111111, 6'b111111, 1'b1);
    // Reset while locked by owner 4
    step(1'b0, 6'b110000, 6'b000000, 1'b1);
    step(1'b0, 6'b010000, 6'b000000, 1'b1);
    chk("tp6_owner", 32'(owner), 4);
    step(1'b1, 6'b010001, 6'b000000, 1'b1);
    step(1'b0, 6'b010001, 6'b111111, 1'b1);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 63) == 0, N'($urandom_range(0, 63)),
           N'($urandom_range(0, 63)), $urandom_range(0, 4) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
